// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU, with a
// one-entry registered response buffer and per-requester saturating grant counters.
module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [2:0]       req0_op,
  input  logic [2:0]       req1_op,
  output logic [31:0]      alu_srca,
  output logic [31:0]      alu_srcb,
  output logic [2:0]       alu_ctrl,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             last_q;
  logic             rsp_id_q;
  logic [31:0]      rsp_result_q;
  logic             rsp_zero_q;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  logic       grant_en;
  logic [1:0] gnt;
  logic       gnt_any;

  // A full response buffer can still accept when it retires on the same edge.
  assign grant_en = (state_q == IDLE) || rsp_ready;
  // last_q == 1 means requester 0 wins a tie next.
  assign gnt[0]   = grant_en && req0_valid && (!req1_valid || last_q);
  assign gnt[1]   = grant_en && req1_valid && (!req0_valid || !last_q);
  assign gnt_any  = gnt[0] || gnt[1];

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  always_comb begin
    alu_srca = '0;
    alu_srcb = '0;
    alu_ctrl = '0;
    if (gnt[0]) begin
      alu_srca = req0_a;
      alu_srcb = req0_b;
      alu_ctrl = req0_op;
    end else if (gnt[1]) begin
      alu_srca = req1_a;
      alu_srcb = req1_b;
      alu_ctrl = req1_op;
    end
  end

  always_comb begin
    state_d = state_q;
    if (gnt_any) begin
      state_d = HOLD;
    end else if (state_q == HOLD && rsp_ready) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i];
      if (gnt[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
      if (gnt_any) begin
        rsp_result_q <= alu_result;
        rsp_zero_q   <= alu_zero;
        rsp_id_q     <= gnt[1];
        last_q       <= gnt[1];
      end
    end
  end

  assign rsp_valid  = (state_q == HOLD);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign grant_cnt0 = cnt_q[0];
  assign grant_cnt1 = cnt_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural ALU on the shared port and a
// response scoreboard filled at acceptance and drained when the response retires.
module tb_alu_arbiter;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0]   req0_a, req0_b, req1_a, req1_b;
  logic [2:0]    req0_op, req1_op;
  logic [31:0]   alu_srca, alu_srcb, alu_result;
  logic [2:0]    alu_ctrl;
  logic          alu_zero;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [31:0]   rsp_result;
  logic [CW-1:0] grant_cnt0, grant_cnt1;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        z;
  } rsp_t;

  rsp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_cnt0 = 0;
  int   exp_cnt1 = 0;
  int   cnt_max = (1 << CW) - 1;

  always #5 clk = ~clk;

  alu_arbiter #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_ref(alu_srca, alu_srcb, alu_ctrl);
    alu_zero   = (alu_result == 32'd0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; exp_g is the requester the bench expects granted (-1 none).
  task automatic cycle(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [2:0] op0, input logic v1, input logic [31:0] a1,
                       input logic [31:0] b1, input logic [2:0] op1, input logic rr,
                       input int exp_g);
    rsp_t e;
    logic [31:0] ea, eb;
    logic [2:0]  eop;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    rsp_ready  = rr;
    #1;
    chk("req0_ready", 64'(req0_ready), 64'(exp_g == 0));
    chk("req1_ready", 64'(req1_ready), 64'(exp_g == 1));
    ea  = (exp_g == 0) ? a0  : (exp_g == 1) ? a1  : 32'd0;
    eb  = (exp_g == 0) ? b0  : (exp_g == 1) ? b1  : 32'd0;
    eop = (exp_g == 0) ? op0 : (exp_g == 1) ? op1 : 3'd0;
    chk("alu_srca", 64'(alu_srca), 64'(ea));
    chk("alu_srcb", 64'(alu_srcb), 64'(eb));
    chk("alu_ctrl", 64'(alu_ctrl), 64'(eop));
    if (q.size() > 0) begin
      chk("rsp_valid", 64'(rsp_valid), 64'd1);
      chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
      chk("rsp_result", 64'(rsp_result), 64'(q[0].res));
      chk("rsp_zero", 64'(rsp_zero), 64'(q[0].z));
      if (rr) void'(q.pop_front());
    end else begin
      chk("rsp_valid_idle", 64'(rsp_valid), 64'd0);
    end
    if (exp_g >= 0) begin
      e.id  = (exp_g == 1);
      e.res = alu_ref(ea, eb, eop);
      e.z   = (e.res == 32'd0);
      q.push_back(e);
      if (exp_g == 0 && exp_cnt0 < cnt_max) exp_cnt0++;
      if (exp_g == 1 && exp_cnt1 < cnt_max) exp_cnt1++;
    end
    $display("t=%0t v=%b%b rr=%b exp_g=%0d rdy=%b%b rsp_v=%b id=%b res=%h cnt=%0d/%0d",
             $time, v1, v0, rr, exp_g, req1_ready, req0_ready, rsp_valid, rsp_id,
             rsp_result, grant_cnt0, grant_cnt1);
    @(posedge clk);
    #1;
    chk("grant_cnt0", 64'(grant_cnt0), 64'(exp_cnt0));
    chk("grant_cnt1", 64'(grant_cnt1), 64'(exp_cnt1));
    chk("rsp_valid_post", 64'(rsp_valid), 64'(q.size() > 0));
  endtask

  task automatic idle(input logic rr);
    cycle(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 32'd0, 32'd0, 3'd0, rr, -1);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_result"}, 64'(rsp_result), 64'd0);
    chk({tag, "_rsp_zero"}, 64'(rsp_zero), 64'd0);
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
    chk({tag, "_cnt0"}, 64'(grant_cnt0), 64'd0);
    chk({tag, "_cnt1"}, 64'(grant_cnt1), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0; req0_op = '0; req1_op = '0;
    #1;
    reset_checks("por");
    chk("por_req0_ready", 64'(req0_ready), 64'd0);
    #11 rst_n = 1'b1;

    // Single add on requester 0, then drain.
    cycle(1'b1, 32'd5, 32'd7, 3'b000, 1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 0);
    idle(1'b1);
    idle(1'b1);

    // Signed slt on requester 1, drained.
    cycle(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 32'hFFFF_FFFF, 32'd1, 3'b100, 1'b1, 1);
    idle(1'b1);

    // Both valid with continuous consumer: 0,1,0,1 at one per cycle; undefined op passes.
    cycle(1'b1, 32'd10, 32'd20, 3'b000, 1'b1, 32'd50, 32'd8, 3'b001, 1'b1, 0);
    cycle(1'b1, 32'hF0F0, 32'h0FF0, 3'b010, 1'b1, 32'd50, 32'd8, 3'b001, 1'b1, 1);
    cycle(1'b1, 32'd1, 32'hFFFF_FFFF, 3'b000, 1'b1, 32'd2, 32'd9, 3'b101, 1'b1, 0);
    cycle(1'b1, 32'd1, 32'd2, 3'b011, 1'b1, 32'd7, 32'd3, 3'b111, 1'b1, 1);

    // Back-pressure: held response stays put, pending sub is not accepted.
    cycle(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 32'd3, 32'd3, 3'b001, 1'b0, -1);
    cycle(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 32'd3, 32'd3, 3'b001, 1'b0, -1);
    cycle(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 32'd3, 32'd3, 3'b001, 1'b0, -1);
    cycle(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 32'd3, 32'd3, 3'b001, 1'b1, 1);
    idle(1'b1);

    // rsp_ready low in IDLE must not block acceptance.
    cycle(1'b1, 32'hF0, 32'h0F, 3'b011, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 0);
    idle(1'b1);

    // Get into HOLD, then reset asynchronously between edges.
    cycle(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 32'd4, 32'd1, 3'b001, 1'b1, 1);
    rst_n = 1'b0;
    q.delete();
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    #1;
    reset_checks("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Requester 0 wins first after reset, then saturate its counter.
    cycle(1'b1, 32'd1, 32'd1, 3'b000, 1'b1, 32'd2, 32'd2, 3'b000, 1'b1, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 32'(i), 32'd3, 3'b000, 1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 0);
    end
    idle(1'b1);
    idle(1'b0);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: CNT_W, default 16, width of the per-requester grant counters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester n has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  requester n's operation is accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  32  operands for requester n.
REQ-007 req0_op / req1_op  input  3  ALU control code: 000 add, 001 sub, 010 and, 011 or, 1xx slt.
REQ-008 alu_srca, alu_srcb  output  32  operands driven to the shared ALU.
REQ-009 alu_ctrl  output  3  control code driven to the shared ALU.
REQ-010 alu_result  input  32  combinational ALU result.
REQ-011 alu_zero  input  1  combinational ALU zero flag.
REQ-012 rsp_valid  output  1  response register holds a result.
REQ-013 rsp_ready  input  1  consumer accepts the response this cycle.
REQ-014 rsp_id  output  1  requester that owns the response (0 or 1).
REQ-015 rsp_result, rsp_zero  output  32/1  registered ALU result and zero flag.
REQ-016 grant_cnt0 / grant_cnt1  output  CNT_W  saturating count of accepted operations per requester.

Function
REQ-017 The FSM SHALL have exactly two states: IDLE (response register empty) and HOLD (response register full).
REQ-018 Grant is enabled when state is IDLE, or when state is HOLD and rsp_ready is 1; otherwise both reqN_ready SHALL be 0.
REQ-019 With grant enabled and exactly one reqN_valid at 1, that requester SHALL be granted.
REQ-020 With grant enabled and both valid, the requester other than the last granted one SHALL be granted (round-robin); after reset, requester 0 has priority.
REQ-021 Ready SHALL be combinational: granted reqN_ready is 1 and the other is 0; ready SHALL never be 1 without the matching valid.
REQ-022 While a grant is active, alu_srca/alu_srcb/alu_ctrl SHALL equal the granted requester's a/b/op, passed through unmodified; otherwise they SHALL be 0/0/000.
REQ-023 On a granting edge: rsp_result<=alu_result, rsp_zero<=alu_zero, rsp_id<=granted index, rsp_valid<=1, state<=HOLD, last-grant pointer<=granted index; latency from acceptance to rsp_valid SHALL be 1 cycle.
REQ-024 In HOLD with rsp_ready=0: rsp_* SHALL remain stable and no new request SHALL be accepted.
REQ-025 In HOLD with rsp_ready=1 and no valid request: rsp_valid<=0, state<=IDLE.
REQ-026 In HOLD with rsp_ready=1 and a valid request: the old response retires and the new one loads on the same edge (sustained throughput of 1 operation/cycle).
REQ-027 In IDLE, rsp_ready SHALL be ignored.
REQ-028 grant_cntN SHALL increment by 1 on each edge where reqN is granted, saturating at 2^CNT_W-1 (no wrap).
REQ-029 The block SHALL not interpret op codes; undefined codes 101-111 SHALL pass through to the ALU.

Reset
REQ-030 While rst_n=0, independent of clk: state=IDLE, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_id=0, last-grant pointer=1 (requester 0 next), grant_cnt0=grant_cnt1=0.
REQ-031 Reset asserted in HOLD SHALL discard the held response with no handshake; the first grant after release SHALL go to requester 0 if it is valid.

Verification
REQ-032 req0 add a=5 b=7, rsp_ready=1 -> req0_ready=1 in the acceptance cycle; next cycle rsp_valid=1, rsp_result=12, rsp_zero=0, rsp_id=0, grant_cnt0=1.
REQ-033 Both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0; one response per cycle, with rsp_id matching.
REQ-034 HOLD with rsp_ready=0 and req1 sub a=3 b=3 pending -> req1_ready=0 and rsp_* stable for 3 cycles; after rsp_ready=1 -> next response rsp_result=0, rsp_zero=1, rsp_id=1.
REQ-035 req1 slt a=0xFFFFFFFF b=1 -> rsp_result=1; req0 or a=0xF0 b=0x0F -> rsp_result=0xFF.
REQ-036 rst_n pulsed low while in HOLD -> rsp_valid=0 immediately and counters=0; with both requesters valid after release, requester 0 is granted first.
REQ-037 CNT_W=2, 5 grants to req0 -> grant_cnt0 reaches 3 and holds at 3.
